// File: rtl/ids_pipe.sv
// ID stage: 2R/1W register file with write-through, destination select, immediate extension,
// load-use interlock and flush, registered into the ID/EX stage. Optional macro: IDS_FWD_EN.
module ids_pipe #(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [XLEN-1:0] pc_i,
   input  logic [5:0]      op_i,
   input  logic [5:0]      func_i,
   input  logic [AW-1:0]   rs_i,
   input  logic [AW-1:0]   rt_i,
   input  logic [AW-1:0]   rd_i,
   input  logic [4:0]      shamt_i,
   input  logic [15:0]     imme_i,
   input  logic [1:0]      regdst_i,
   input  logic [1:0]      ext_mode_i,
   input  logic            ex_is_load_i,
   input  logic [AW-1:0]   ex_dst_i,
   input  logic            flush_i,
   input  logic            wb_we_i,
   input  logic [AW-1:0]   wb_addr_i,
   input  logic [XLEN-1:0] wb_data_i,
`ifdef IDS_FWD_EN
   input  logic            mem_we_i,
   input  logic [AW-1:0]   mem_addr_i,
   input  logic [XLEN-1:0] mem_data_i,
`endif
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] ra_o,
   output logic [XLEN-1:0] rb_o,
   output logic [XLEN-1:0] immeo_o,
   output logic [XLEN-1:0] pco_o,
   output logic [AW-1:0]   dst_o,
   output logic [5:0]      op_o,
   output logic [5:0]      func_o,
   output logic [4:0]      shamt_o
);

   localparam int NREG = 2**AW;

   logic [XLEN-1:0] rf_q [NREG];
   logic [AW-1:0]   raddr [2];
   logic [XLEN-1:0] rdata [2];

   logic            hazard, advance, accept;
   logic [XLEN-1:0] sext, imm_d;
   logic [AW-1:0]   dst_d;

   logic            out_valid_q;
   logic [XLEN-1:0] ra_q, rb_q, imm_q, pc_q;
   logic [AW-1:0]   dst_q;
   logic [5:0]      op_q, func_q;
   logic [4:0]      shamt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (wb_we_i && wb_addr_i != '0) begin
         rf_q[wb_addr_i] <= wb_data_i;
      end
   end

   assign raddr[0] = rs_i;
   assign raddr[1] = rt_i;

   // Newest producer wins: EX/MEM (when built in), then the same-cycle WB write, then the array
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdata[p] = rf_q[raddr[p]];
         if (raddr[p] == '0) rdata[p] = '0;
`ifdef IDS_FWD_EN
         else if (mem_we_i && mem_addr_i == raddr[p]) rdata[p] = mem_data_i;
`endif
         else if (wb_we_i && wb_addr_i == raddr[p]) rdata[p] = wb_data_i;
      end
   end

   assign hazard     = in_valid_i && ex_is_load_i && (ex_dst_i != '0) &&
                       ((ex_dst_i == rs_i) || (ex_dst_i == rt_i));
   assign advance    = !out_valid_q || out_ready_i;
   assign in_ready_o = advance && !hazard;
   assign accept     = in_valid_i && in_ready_o;

   // Shifting the sign-extended value also sign-extends bit 31 when XLEN > 32
   assign sext = {{(XLEN-16){imme_i[15]}}, imme_i};

   always_comb begin
      imm_d = sext;
      unique case (ext_mode_i)
         2'b00: imm_d = sext;
         2'b01: imm_d = {{(XLEN-16){1'b0}}, imme_i};
         2'b10: imm_d = sext << 16;
         2'b11: imm_d = {{(XLEN-5){1'b0}}, shamt_i};
         default: imm_d = sext;
      endcase
   end

   always_comb begin
      dst_d = '0;
      unique case (regdst_i)
         2'b00: dst_d = rt_i;
         2'b01: dst_d = rd_i;
         2'b10: dst_d = '1;
         2'b11: dst_d = '0;
         default: dst_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         ra_q        <= '0;
         rb_q        <= '0;
         imm_q       <= '0;
         pc_q        <= '0;
         dst_q       <= '0;
         op_q        <= '0;
         func_q      <= '0;
         shamt_q     <= '0;
      end else if (advance) begin
         if (accept && !flush_i) begin
            out_valid_q <= 1'b1;
            ra_q        <= rdata[0];
            rb_q        <= rdata[1];
            imm_q       <= imm_d;
            pc_q        <= pc_i;
            dst_q       <= dst_d;
            op_q        <= op_i;
            func_q      <= func_i;
            shamt_q     <= shamt_i;
         end else begin
            out_valid_q <= 1'b0;
         end
      end else if (flush_i) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid_o = out_valid_q;
   assign ra_o        = ra_q;
   assign rb_o        = rb_q;
   assign immeo_o     = imm_q;
   assign pco_o       = pc_q;
   assign dst_o       = dst_q;
   assign op_o        = op_q;
   assign func_o      = func_q;
   assign shamt_o     = shamt_q;

endmodule

// File: tb/tb_ids_pipe.sv
// Self-checking bench for ids_pipe: vector table through a scoreboard, then hand-written
// sequences for interlock, stall, flush and asynchronous reset.
module tb_ids_pipe;
   localparam int XLEN = 32;
   localparam int AW   = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid, in_ready, out_valid, out_ready;
   logic [XLEN-1:0] pc, wb_data, ra, rb, immeo, pco;
   logic [5:0]      op, func, op_o, func_o;
   logic [AW-1:0]   rs, rt, rd, ex_dst, wb_addr, dst;
   logic [4:0]      shamt, shamt_o;
   logic [15:0]     imme;
   logic [1:0]      regdst, ext_mode;
   logic            ex_is_load, flush, wb_we;
`ifdef IDS_FWD_EN
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [XLEN-1:0] mem_data;
`endif

   always #5 clk = ~clk;

   ids_pipe #(.XLEN(XLEN), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .pc_i(pc), .op_i(op), .func_i(func), .rs_i(rs), .rt_i(rt), .rd_i(rd),
      .shamt_i(shamt), .imme_i(imme), .regdst_i(regdst), .ext_mode_i(ext_mode),
      .ex_is_load_i(ex_is_load), .ex_dst_i(ex_dst), .flush_i(flush),
      .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
`ifdef IDS_FWD_EN
      .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_data_i(mem_data),
`endif
      .out_valid_o(out_valid), .out_ready_i(out_ready), .ra_o(ra), .rb_o(rb),
      .immeo_o(immeo), .pco_o(pco), .dst_o(dst), .op_o(op_o), .func_o(func_o),
      .shamt_o(shamt_o)
   );

   typedef struct {
      logic [31:0] pc;
      logic [5:0]  op, func;
      logic [4:0]  rs, rt, rd, shamt;
      logic [15:0] imme;
      logic [1:0]  regdst, ext;
      logic        wb_we;
      logic [4:0]  wb_addr;
      logic [31:0] wb_data;
      logic [31:0] e_ra, e_rb, e_imm;
      logic [4:0]  e_dst;
   } vec_t;

   typedef struct {
      logic [31:0] ra, rb, imm, pc;
      logic [4:0]  dst, shamt;
      logic [5:0]  op, func;
   } exp_t;

   vec_t vecs[6];
   exp_t sb[$];
   exp_t e;
   int   n_pass = 0;
   int   n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      pc = v.pc; op = v.op; func = v.func; rs = v.rs; rt = v.rt; rd = v.rd;
      shamt = v.shamt; imme = v.imme; regdst = v.regdst; ext_mode = v.ext;
      wb_we = v.wb_we; wb_addr = v.wb_addr; wb_data = v.wb_data;
      in_valid = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 0; out_ready = 1; pc = 0; op = 0; func = 0;
      rs = 0; rt = 0; rd = 0; shamt = 0; imme = 0; regdst = 0; ext_mode = 0;
      ex_is_load = 0; ex_dst = 0; flush = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
`ifdef IDS_FWD_EN
      mem_we = 0; mem_addr = 0; mem_data = 0;
`endif
      #12;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_ra", ra, 32'h0);
      chk("rst_immeo", immeo, 32'h0);
      chk("rst_dst", {27'b0, dst}, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 1; i <= 7; i++) begin
         wb_we = 1; wb_addr = 5'(i); wb_data = 32'hA000_0000 | 32'(i);
         tick();
      end
      wb_we = 0;

      //          pc         op    func  rs  rt  rd     sh  imme      rd  ext we  wa  wdata          ra             rb             imm            dst
      vecs[0] = '{32'h100, 6'h01, 6'h02, 1,  2,  3,     4,  16'h8001, 0,  0,  0,  0,  32'h0,         32'hA000_0001, 32'hA000_0002, 32'hFFFF_8001, 2};
      vecs[1] = '{32'h104, 6'h03, 6'h04, 3,  4,  9,     5,  16'h8001, 1,  1,  0,  0,  32'h0,         32'hA000_0003, 32'hA000_0004, 32'h0000_8001, 9};
      vecs[2] = '{32'h108, 6'h05, 6'h06, 5,  0,  1,     6,  16'h8001, 2,  2,  1,  5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0,         32'h8001_0000, 31};
      vecs[3] = '{32'h10C, 6'h07, 6'h08, 0,  5,  2,     31, 16'h8001, 3,  3,  1,  0,  32'hFFFF_FFFF, 32'h0,         32'hDEAD_BEEF, 32'h0000_001F, 0};
      vecs[4] = '{32'h110, 6'h09, 6'h0A, 6,  7,  3,     0,  16'h7FFF, 0,  0,  0,  6,  32'h1234,      32'hA000_0006, 32'hA000_0007, 32'h0000_7FFF, 7};
      vecs[5] = '{32'h114, 6'h3F, 6'h3E, 2,  2,  5'h1E, 1,  16'h1234, 1,  2,  1,  2,  32'h5555_AAAA, 32'h5555_AAAA, 32'h5555_AAAA, 32'h1234_0000, 5'h1E};

      foreach (vecs[k]) begin
         drive(vecs[k]);
         #1 chk($sformatf("v%0d_in_ready", k), {31'b0, in_ready}, 32'd1);
         sb.push_back('{vecs[k].e_ra, vecs[k].e_rb, vecs[k].e_imm, vecs[k].pc,
                        vecs[k].e_dst, vecs[k].shamt, vecs[k].op, vecs[k].func});
         tick();
         wb_we = 0;
         chk($sformatf("v%0d_out_valid", k), {31'b0, out_valid}, 32'd1);
         e = sb.pop_front();
         chk($sformatf("v%0d_ra", k), ra, e.ra);
         chk($sformatf("v%0d_rb", k), rb, e.rb);
         chk($sformatf("v%0d_imm", k), immeo, e.imm);
         chk($sformatf("v%0d_dst", k), {27'b0, dst}, {27'b0, e.dst});
         chk($sformatf("v%0d_pc", k), pco, e.pc);
         chk($sformatf("v%0d_opfs", k), {15'b0, op_o, func_o, shamt_o},
             {15'b0, e.op, e.func, e.shamt});
      end
      in_valid = 0;

      // load-use interlock inserts a bubble, then accepts once the load is gone
      in_valid = 1; rs = 1; rt = 7; regdst = 0; ext_mode = 0; pc = 32'h200;
      ex_is_load = 1; ex_dst = 7;
      #1 chk("haz_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
      chk("haz_bubble", {31'b0, out_valid}, 32'd0);
      chk("haz_ra_hold", ra, 32'h5555_AAAA);
      ex_is_load = 0;
      #1 chk("haz_release_ready", {31'b0, in_ready}, 32'd1);
      tick();
      chk("haz_out_valid", {31'b0, out_valid}, 32'd1);
      chk("haz_ra", ra, 32'hA000_0001);
      chk("haz_rb", rb, 32'hA000_0007);

      // downstream stall for three cycles
      out_ready = 0; rs = 3; rt = 4; pc = 32'h300;
      for (int c = 0; c < 3; c++) begin
         #1 chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
         tick();
         chk("stall_valid", {31'b0, out_valid}, 32'd1);
         chk("stall_ra", ra, 32'hA000_0001);
         chk("stall_rb", rb, 32'hA000_0007);
         chk("stall_dst", {27'b0, dst}, 32'd7);
         chk("stall_pc", pco, 32'h200);
      end
      out_ready = 1;
      #1 chk("unstall_in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      chk("unstall_ra", ra, 32'hA000_0003);
      chk("unstall_pc", pco, 32'h300);
      chk("unstall_dst", {27'b0, dst}, 32'd4);

      // flush drops the accepted instruction but still lets WB write
      flush = 1; rs = 4; pc = 32'h304; wb_we = 1; wb_addr = 8; wb_data = 32'h88;
      tick();
      chk("flush_valid", {31'b0, out_valid}, 32'd0);
      chk("flush_ra_hold", ra, 32'hA000_0003);
      flush = 0; wb_we = 0; rs = 8; rt = 0; pc = 32'h400;
      tick();
      chk("postflush_valid", {31'b0, out_valid}, 32'd1);
      chk("postflush_ra", ra, 32'h88);
      out_ready = 0; flush = 1; in_valid = 0;
      tick();
      chk("flush_stall_valid", {31'b0, out_valid}, 32'd0);
      flush = 0; out_ready = 1;

      // asynchronous reset mid-stream
      in_valid = 1; rs = 1; rt = 5; regdst = 1; rd = 3; ext_mode = 1; imme = 16'hFFFF;
      tick();
      chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
      #1 rst_n = 0;
      #1;
      chk("arst_valid", {31'b0, out_valid}, 32'd0);
      chk("arst_ra", ra, 32'h0);
      chk("arst_pc", pco, 32'h0);
      chk("arst_imm", immeo, 32'h0);
      chk("arst_dst", {27'b0, dst}, 32'd0);
      @(negedge clk) rst_n = 1;
      tick();
      chk("rf_cleared_ra", ra, 32'h0);
      chk("rf_cleared_rb", rb, 32'h0);
      in_valid = 0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
